ncu_pio_credit_ctl: RTL and testbench



---
 rtl/ncu_pio_pkg.sv | 27 ++
 rtl/ncu_pio_tag_pool.sv | 91 +++++++++
 rtl/ncu_pio_credit_ctl.sv | 104 ++++++++++
 tb/tb_ncu_pio_credit_ctl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ncu_pio_pkg.sv
// Shared definitions for the NCU->DMU PIO credit sequencer: header field
// positions, tag width, FSM state encoding and a tag popcount helper.
package ncu_pio_pkg;

    localparam int PIO_RD_BIT   = 60;
    localparam int PIO_TAG_MSB  = 59;
    localparam int PIO_TAG_LSB  = 56;
    localparam int PIO_TAG_W    = 4;
    localparam int PIO_MAX_TAGS = 1 << PIO_TAG_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
    } pio_st_e;

    // Number of set bits in a tag vector; the result is wide enough for all tags.
    function automatic logic [PIO_TAG_W:0] popcount_tags(input logic [PIO_MAX_TAGS-1:0] v);
        logic [PIO_TAG_W:0] c;
        c = '0;
        for (int i = 0; i < PIO_MAX_TAGS; i++) begin
            c = c + {{PIO_TAG_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/ncu_pio_tag_pool.sv
// Credit tag pool: per-tag busy/is_rd state, lowest-free allocation,
// return legality checking and the registered free-credit count.
module ncu_pio_tag_pool
    import ncu_pio_pkg::*;
#(
    parameter int NUM_CREDITS = 16
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 alloc,
    input  logic                 alloc_rd,
    output logic [PIO_TAG_W-1:0] free_tag,
    output logic                 any_free,
    input  logic                 wr_ret_vld,
    input  logic [PIO_TAG_W-1:0] wr_ret_tag,
    input  logic                 rd_ret_vld,
    input  logic [PIO_TAG_W-1:0] rd_ret_tag,
    output logic                 err_bad_ret,
    output logic [PIO_TAG_W:0]   credits_free
);

    localparam logic [PIO_TAG_W:0] CRED_MAX = NUM_CREDITS[PIO_TAG_W:0];

    logic [PIO_MAX_TAGS-1:0] busy_reg, busy_next;
    logic [PIO_MAX_TAGS-1:0] is_rd_reg, is_rd_next;
    logic [PIO_MAX_TAGS-1:0] valid_mask, free_mask;
    logic                    wr_legal, rd_legal, do_alloc;
    logic                    err_reg;
    logic [PIO_TAG_W:0]      credits_reg;

    // Tags at or above NUM_CREDITS never exist: they are never free, never busy.
    generate
        for (genvar gi = 0; gi < PIO_MAX_TAGS; gi++) begin : g_tag
            if (gi < NUM_CREDITS) begin : g_live
                logic hit_alloc, hit_ret;
                assign valid_mask[gi] = 1'b1;
                assign hit_alloc      = do_alloc && (free_tag == PIO_TAG_W'(gi));
                assign hit_ret        = (wr_legal && (wr_ret_tag == PIO_TAG_W'(gi))) ||
                                        (rd_legal && (rd_ret_tag == PIO_TAG_W'(gi)));
                assign busy_next[gi]  = hit_alloc ? 1'b1 : (hit_ret ? 1'b0 : busy_reg[gi]);
                assign is_rd_next[gi] = hit_alloc ? alloc_rd : is_rd_reg[gi];
            end else begin : g_absent
                assign valid_mask[gi] = 1'b0;
                assign busy_next[gi]  = 1'b0;
                assign is_rd_next[gi] = 1'b0;
            end
        end
    endgenerate

    assign free_mask = ~busy_reg & valid_mask;
    assign any_free  = |free_mask;
    assign do_alloc  = alloc && any_free;

    // Lowest-index free tag; scanning downward lets the lowest hit win.
    always_comb begin
        free_tag = '0;
        for (int i = PIO_MAX_TAGS - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                free_tag = PIO_TAG_W'(i);
            end
        end
    end

    // A return is legal only for an in-range, busy tag of the matching type.
    always_comb begin
        wr_legal = wr_ret_vld && (int'(wr_ret_tag) < NUM_CREDITS) &&
                   busy_reg[wr_ret_tag] && !is_rd_reg[wr_ret_tag];
        rd_legal = rd_ret_vld && (int'(rd_ret_tag) < NUM_CREDITS) &&
                   busy_reg[rd_ret_tag] && is_rd_reg[rd_ret_tag];
    end

    // Pool state, error pulse and free count; the count tracks busy_next so it
    // lines up with the busy vector it describes.
    always_ff @(posedge clk) begin
        if (srst) begin
            busy_reg    <= '0;
            is_rd_reg   <= '0;
            err_reg     <= 1'b0;
            credits_reg <= CRED_MAX;
        end else begin
            busy_reg    <= busy_next;
            is_rd_reg   <= is_rd_next;
            err_reg     <= (wr_ret_vld && !wr_legal) || (rd_ret_vld && !rd_legal);
            credits_reg <= CRED_MAX - popcount_tags(busy_next);
        end
    end

    assign err_bad_ret  = err_reg;
    assign credits_free = credits_reg;

endmodule

// File: rtl/ncu_pio_credit_ctl.sv
// NCU->DMU PIO sequencer: accepts one request at a time, stamps it with a
// credit tag, then emits the header cycle and (for writes) the payload cycle.
module ncu_pio_credit_ctl
    import ncu_pio_pkg::*;
#(
    parameter int NUM_CREDITS = 16
) (
    input  logic        iol2clk,
    input  logic        rst,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic        req_rd,
    input  logic [63:0] req_hdr,
    input  logic [63:0] req_data,
    output logic        ncu_dmu_pio_hdr_vld,
    output logic [63:0] ncu_dmu_pio_data,
    input  logic        dmu_ncu_wrack_vld,
    input  logic [3:0]  dmu_ncu_wrack_tag,
    input  logic        rd_ret_vld,
    input  logic [3:0]  rd_ret_tag,
    output logic [4:0]  credits_free,
    output logic        err_bad_ret
);

    pio_st_e                state_reg, state_next;
    logic [63:0]            hdr_reg, pay_reg, hdr_next;
    logic                   rd_reg;
    logic                   accept, any_free;
    logic [PIO_TAG_W-1:0]   free_tag;

    ncu_pio_tag_pool #(
        .NUM_CREDITS (NUM_CREDITS)
    ) u_pool (
        .clk          (iol2clk),
        .srst         (rst),
        .alloc        (accept),
        .alloc_rd     (req_rd),
        .free_tag     (free_tag),
        .any_free     (any_free),
        .wr_ret_vld   (dmu_ncu_wrack_vld),
        .wr_ret_tag   (dmu_ncu_wrack_tag),
        .rd_ret_vld   (rd_ret_vld),
        .rd_ret_tag   (rd_ret_tag),
        .err_bad_ret  (err_bad_ret),
        .credits_free (credits_free)
    );

    // Ready only while idle with a free tag; held low while reset is asserted.
    assign req_rdy = (state_reg == IDLE) && any_free && !rst;
    assign accept  = req_vld && req_rdy;

    // Header with the type bit and allocated tag spliced over the template.
    always_comb begin
        hdr_next                          = req_hdr;
        hdr_next[PIO_RD_BIT]              = req_rd;
        hdr_next[PIO_TAG_MSB:PIO_TAG_LSB] = free_tag;
    end

    // State register plus the latched header/payload of the request in flight.
    always_ff @(posedge iol2clk) begin
        if (rst) begin
            state_reg <= IDLE;
            hdr_reg   <= '0;
            pay_reg   <= '0;
            rd_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                hdr_reg <= hdr_next;
                rd_reg  <= req_rd;
                if (!req_rd) begin
                    pay_reg <= req_data;
                end
            end
        end
    end

    // Next-state logic and the outbound header/payload mux.
    always_comb begin
        state_next          = state_reg;
        ncu_dmu_pio_hdr_vld = 1'b0;
        ncu_dmu_pio_data    = '0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = HDR;
                end
            end
            HDR: begin
                ncu_dmu_pio_hdr_vld = 1'b1;
                ncu_dmu_pio_data    = hdr_reg;
                state_next          = rd_reg ? IDLE : PAY;
            end
            PAY: begin
                ncu_dmu_pio_data = pay_reg;
                state_next       = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ncu_pio_credit_ctl.sv
// Scoreboard bench: expected output beats are queued at accept time and
// popped as the DUT emits them; a reference pool model predicts tags,
// error pulses, free counts and ready. A second instance uses 4 credits.
module tb_ncu_pio_credit_ctl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (16 credits)
    logic        rst = 1'b1, req_vld = 1'b0, req_rd = 1'b0;
    logic        req_rdy, hdr_vld, err;
    logic [63:0] req_hdr = '0, req_data = '0, data;
    logic        wr_vld = 1'b0, rr_vld = 1'b0;
    logic [3:0]  wr_tag = '0, rr_tag = '0;
    logic [4:0]  credits;

    // Small instance (4 credits)
    logic        b_rst = 1'b1, b_req_vld = 1'b0, b_req_rd = 1'b0;
    logic        b_req_rdy, b_hdr_vld, b_err;
    logic [63:0] b_req_hdr = '0, b_req_data = '0, b_data;
    logic        b_wr_vld = 1'b0, b_rr_vld = 1'b0;
    logic [3:0]  b_wr_tag = '0, b_rr_tag = '0;
    logic [4:0]  b_credits;

    ncu_pio_credit_ctl #(.NUM_CREDITS(16)) dut (
        .iol2clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy),
        .req_rd(req_rd), .req_hdr(req_hdr), .req_data(req_data),
        .ncu_dmu_pio_hdr_vld(hdr_vld), .ncu_dmu_pio_data(data),
        .dmu_ncu_wrack_vld(wr_vld), .dmu_ncu_wrack_tag(wr_tag),
        .rd_ret_vld(rr_vld), .rd_ret_tag(rr_tag),
        .credits_free(credits), .err_bad_ret(err)
    );

    ncu_pio_credit_ctl #(.NUM_CREDITS(4)) dut4 (
        .iol2clk(clk), .rst(b_rst), .req_vld(b_req_vld), .req_rdy(b_req_rdy),
        .req_rd(b_req_rd), .req_hdr(b_req_hdr), .req_data(b_req_data),
        .ncu_dmu_pio_hdr_vld(b_hdr_vld), .ncu_dmu_pio_data(b_data),
        .dmu_ncu_wrack_vld(b_wr_vld), .dmu_ncu_wrack_tag(b_wr_tag),
        .rd_ret_vld(b_rr_vld), .rd_ret_tag(b_rr_tag),
        .credits_free(b_credits), .err_bad_ret(b_err)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model of the main instance
    typedef struct {
        logic        hv;
        logic [63:0] d;
    } beat_t;

    beat_t sb[$];
    bit    m_busy[16];
    bit    m_rd[16];
    int    m_state = 0;   // 0 idle, 1 header, 2 payload
    bit    m_cur_rd = 1'b0;

    function automatic int m_free_cnt();
        int c = 0;
        for (int t = 0; t < 16; t++) if (!m_busy[t]) c++;
        return c;
    endfunction

    function automatic int m_lowest();
        for (int t = 0; t < 16; t++) if (!m_busy[t]) return t;
        return -1;
    endfunction

    // One clock of the main instance: predict, advance, then compare.
    task automatic cyc();
        logic        acc;
        bit          e, wr_ok, rd_ok;
        int          t, nstate;
        logic [63:0] h;
        beat_t       bt;
        acc = req_vld && req_rdy;
        e   = 1'b0;
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_busy[i] = 1'b0;
                m_rd[i]   = 1'b0;
            end
            m_state = 0;
            sb.delete();
        end else begin
            t      = m_lowest();
            wr_ok  = wr_vld && m_busy[wr_tag] && !m_rd[wr_tag];
            rd_ok  = rr_vld && m_busy[rr_tag] && m_rd[rr_tag];
            e      = (wr_vld && !wr_ok) || (rr_vld && !rd_ok);
            nstate = (m_state == 0) ? (acc ? 1 : 0) : (m_state == 1) ? (m_cur_rd ? 0 : 2) : 0;
            if (wr_ok) m_busy[wr_tag] = 1'b0;
            if (rd_ok) m_busy[rr_tag] = 1'b0;
            if (acc && t >= 0) begin
                m_busy[t]    = 1'b1;
                m_rd[t]      = req_rd;
                m_cur_rd     = req_rd;
                h            = req_hdr;
                h[60]        = req_rd;
                h[59:56]     = t[3:0];
                sb.push_back('{1'b1, h});
                if (!req_rd) sb.push_back('{1'b0, req_data});
            end
            m_state = nstate;
        end
        @(posedge clk);
        #1;
        if (m_state != 0) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                bt = sb.pop_front();
                chk("hdr_vld", {63'd0, hdr_vld}, {63'd0, bt.hv});
                chk("pio_data", data, bt.d);
                if (bt.hv)
                    $display("txn hdr tag=%0d rd=%0b data=%h", bt.d[59:56], bt.d[60], data);
                else
                    $display("txn payload data=%h", data);
            end
        end else begin
            chk("idle_hdr_vld", {63'd0, hdr_vld}, 64'd0);
            chk("idle_data", data, 64'd0);
        end
        chk("err_bad_ret", {63'd0, err}, {63'd0, e});
        chk("credits_free", {59'd0, credits}, 64'(m_free_cnt()));
        chk("req_rdy", {63'd0, req_rdy}, {63'd0, (m_state == 0 && m_free_cnt() > 0 && !rst)});
    endtask

    task automatic send(input bit rd, input logic [63:0] h, input logic [63:0] d);
        bit got = 1'b0;
        req_vld = 1'b1; req_rd = rd; req_hdr = h; req_data = d;
        for (int n = 0; n < 40 && !got; n++) begin
            got = req_rdy;
            cyc();
        end
        req_vld = 1'b0;
        if (!got) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic ret(input bit wv, input logic [3:0] wt, input bit rv, input logic [3:0] rt);
        wr_vld = wv; wr_tag = wt; rr_vld = rv; rr_tag = rt;
        cyc();
        wr_vld = 1'b0; rr_vld = 1'b0;
    endtask

    task automatic bstep();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int naccept;
        bit r;
        // Reset values
        repeat (3) cyc();
        rst = 1'b0;
        cyc();

        // Single write: tag 0, header bit 60 clear, then payload
        send(1'b0, 64'h0, 64'hA5);
        repeat (3) cyc();
        chk("credits_after_write", {59'd0, credits}, 64'd15);
        ret(1'b1, 4'd0, 1'b0, 4'd0);
        cyc();

        // 16 back-to-back reads fill the pool in tag order
        for (int i = 0; i < 16; i++) send(1'b1, {$urandom, $urandom}, 64'h0);
        req_vld = 1'b1; req_rd = 1'b1; req_hdr = 64'h1234_5678_9ABC_DEF0;
        repeat (3) cyc();
        chk("pool_full_rdy", {63'd0, req_rdy}, 64'd0);
        chk("pool_full_credits", {59'd0, credits}, 64'd0);
        // Returning tag 7 makes it the next allocation
        rr_vld = 1'b1; rr_tag = 4'd7;
        cyc();
        rr_vld = 1'b0;
        cyc();
        req_vld = 1'b0;
        repeat (2) cyc();

        // Illegal wracks: free tag 3, then busy read tag 5
        ret(1'b0, 4'd0, 1'b1, 4'd3);
        cyc();
        ret(1'b1, 4'd3, 1'b0, 4'd0);
        cyc();
        ret(1'b1, 4'd5, 1'b0, 4'd0);
        cyc();

        // Drain all reads, then set up write tags 0,1 and read tag 2
        for (int t = 0; t < 16; t++) if (t != 3) ret(1'b0, 4'd0, 1'b1, 4'(t));
        cyc();
        send(1'b0, {$urandom, $urandom}, {$urandom, $urandom});
        send(1'b0, {$urandom, $urandom}, {$urandom, $urandom});
        send(1'b1, {$urandom, $urandom}, 64'h0);
        repeat (2) cyc();
        ret(1'b1, 4'd1, 1'b1, 4'd2);   // both legal
        cyc();
        ret(1'b1, 4'd0, 1'b1, 4'd5);   // one legal, one illegal
        repeat (2) cyc();

        // Reset during the payload cycle of a write
        send(1'b0, 64'hFFFF_0000_FFFF_0000, 64'hDEAD_BEEF_0BAD_F00D);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        ret(1'b1, 4'd0, 1'b0, 4'd0);   // pre-reset tag
        cyc();

        // Random traffic with random returns
        for (int i = 0; i < 200; i++) begin
            req_vld  = ($urandom_range(0, 1) == 1);
            req_rd   = ($urandom_range(0, 1) == 1);
            req_hdr  = {$urandom, $urandom};
            req_data = {$urandom, $urandom};
            wr_vld   = ($urandom_range(0, 3) == 0);
            wr_tag   = 4'($urandom_range(0, 15));
            rr_vld   = ($urandom_range(0, 3) == 0);
            rr_tag   = 4'($urandom_range(0, 15));
            cyc();
        end
        req_vld = 1'b0; wr_vld = 1'b0; rr_vld = 1'b0;
        repeat (4) cyc();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        // Four-credit instance
        bstep();
        chk("b_reset_rdy", {63'd0, b_req_rdy}, 64'd0);
        chk("b_reset_credits", {59'd0, b_credits}, 64'd4);
        b_rst = 1'b0;
        bstep();
        chk("b_rdy_after_reset", {63'd0, b_req_rdy}, 64'd1);
        b_wr_vld = 1'b1; b_wr_tag = 4'd5;
        bstep();
        b_wr_vld = 1'b0;
        chk("b_err_tag5", {63'd0, b_err}, 64'd1);
        chk("b_credits_tag5", {59'd0, b_credits}, 64'd4);
        bstep();
        chk("b_err_clear", {63'd0, b_err}, 64'd0);
        b_req_vld = 1'b1; b_req_rd = 1'b1; b_req_hdr = 64'h0;
        naccept = 0;
        for (int n = 0; n < 20; n++) begin
            r = b_req_rdy;
            bstep();
            if (r) begin
                chk("b_hdr_vld", {63'd0, b_hdr_vld}, 64'd1);
                chk("b_tag", {60'd0, b_data[59:56]}, 64'(naccept));
                $display("txn b hdr tag=%0d", b_data[59:56]);
                naccept++;
            end
        end
        b_req_vld = 1'b0;
        chk("b_accepts", 64'(naccept), 64'd4);
        chk("b_full_rdy", {63'd0, b_req_rdy}, 64'd0);
        chk("b_full_credits", {59'd0, b_credits}, 64'd0);
        b_rr_vld = 1'b1; b_rr_tag = 4'd2;
        bstep();
        b_rr_vld = 1'b0;
        chk("b_credit_back", {59'd0, b_credits}, 64'd1);
        chk("b_rdy_back", {63'd0, b_req_rdy}, 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
